// File: rtl/aud_recorder.sv
// I2S capture engine: deserialises the left-channel sample of each frame and
// writes it to consecutive SRAM words, with start/pause/resume/stop control.
module aud_recorder #(
    parameter logic [19:0] MAX_ADDR  = 20'hFFFFF,
    parameter int          WORD_BITS = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_pause,
    input  logic                 i_stop,
    input  logic                 i_adclrck,
    input  logic                 i_bclk,
    input  logic                 i_adcdat,
    output logic [19:0]          o_address,
    output logic [WORD_BITS-1:0] o_data,
    output logic                 o_we,
    output logic [19:0]          o_length,
    output logic                 o_full
);
    localparam int CNT_W = $clog2(WORD_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT_LR = 3'd1,
        S_SKIP    = 3'd2,
        S_SHIFT   = 3'd3,
        S_WRITE   = 3'd4,
        S_PAUSED  = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           bclk_sync_q, bclk_sync_d;
    logic [2:0]           lrck_sync_q, lrck_sync_d;
    logic [1:0]           dat_sync_q, dat_sync_d;
    logic [WORD_BITS-1:0] shift_q, shift_d;
    logic [WORD_BITS-1:0] o_data_q, o_data_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [19:0]          addr_q, addr_d;
    logic [19:0]          o_address_q, o_address_d;
    logic [19:0]          length_q, length_d;
    logic                 o_we_q, o_we_d;
    logic                 full_q, full_d;
    logic                 pause_pend_q, pause_pend_d;
    logic                 bclk_rise_s, lrck_rise_s, lrck_fall_s, dat_bit_s;

    // Codec pin synchronisers; data is taken from the same stage as the bclk edge
    always_comb begin
        bclk_sync_d = {bclk_sync_q[1:0], i_bclk};
        lrck_sync_d = {lrck_sync_q[1:0], i_adclrck};
        dat_sync_d  = {dat_sync_q[0], i_adcdat};
        bclk_rise_s = bclk_sync_q[1] & ~bclk_sync_q[2];
        lrck_rise_s = lrck_sync_q[1] & ~lrck_sync_q[2];
        lrck_fall_s = ~lrck_sync_q[1] & lrck_sync_q[2];
        dat_bit_s   = dat_sync_q[1];
    end

    // Recording FSM and datapath next-state
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        o_address_d  = o_address_q;
        o_data_d     = o_data_q;
        o_we_d       = 1'b0;
        length_d     = length_q;
        full_d       = full_q;
        pause_pend_d = pause_pend_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (i_stop) begin
                    state_d = S_IDLE;
                end else if (i_start) begin
                    state_d     = S_WAIT_LR;
                    addr_d      = 20'd0;
                    o_address_d = 20'd0;
                    length_d    = 20'd0;
                    full_d      = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            S_WAIT_LR: begin
                if (i_stop) begin
                    state_d      = S_IDLE;
                    pause_pend_d = 1'b0;
                end else if (i_pause || pause_pend_q) begin
                    state_d      = S_PAUSED;
                    pause_pend_d = 1'b0;
                end else if (lrck_fall_s) begin
                    state_d = S_SKIP;
                end else begin
                    state_d = S_WAIT_LR;
                end
            end
            S_SKIP, S_SHIFT: begin
                if (i_pause) begin
                    pause_pend_d = 1'b1;
                end else begin
                    pause_pend_d = pause_pend_q;
                end
                if (i_stop) begin
                    state_d      = S_IDLE;
                    pause_pend_d = 1'b0;
                end else if (lrck_rise_s) begin
                    // right channel started early: the partial word is dropped
                    state_d = S_WAIT_LR;
                end else if (bclk_rise_s && (state_q == S_SKIP)) begin
                    state_d = S_SHIFT;
                    cnt_d   = {CNT_W{1'b0}};
                end else if (bclk_rise_s) begin
                    shift_d = {shift_q[WORD_BITS-2:0], dat_bit_s};
                    cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_q == CNT_W'(WORD_BITS - 1)) begin
                        state_d     = S_WRITE;
                        o_we_d      = 1'b1;
                        o_data_d    = shift_d;
                        o_address_d = addr_q;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_WRITE: begin
                // the strobe is on the output during this cycle; commit the word
                length_d     = length_q + 20'd1;
                pause_pend_d = 1'b0;
                if (addr_q == MAX_ADDR) begin
                    full_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    addr_d  = addr_q + 20'd1;
                    state_d = (pause_pend_q || i_pause) ? S_PAUSED : S_WAIT_LR;
                end
                if (i_stop) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = state_d;
                end
            end
            S_PAUSED: begin
                if (i_stop) begin
                    state_d = S_IDLE;
                end else if (i_start) begin
                    state_d = S_WAIT_LR;
                end else begin
                    state_d = S_PAUSED;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            bclk_sync_q  <= 3'b000;
            lrck_sync_q  <= 3'b000;
            dat_sync_q   <= 2'b00;
            shift_q      <= {WORD_BITS{1'b0}};
            cnt_q        <= {CNT_W{1'b0}};
            addr_q       <= 20'd0;
            o_address_q  <= 20'd0;
            o_data_q     <= {WORD_BITS{1'b0}};
            o_we_q       <= 1'b0;
            length_q     <= 20'd0;
            full_q       <= 1'b0;
            pause_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bclk_sync_q  <= bclk_sync_d;
            lrck_sync_q  <= lrck_sync_d;
            dat_sync_q   <= dat_sync_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            o_address_q  <= o_address_d;
            o_data_q     <= o_data_d;
            o_we_q       <= o_we_d;
            length_q     <= length_d;
            full_q       <= full_d;
            pause_pend_q <= pause_pend_d;
        end
    end

    assign o_address = o_address_q;
    assign o_data    = o_data_q;
    assign o_we      = o_we_q;
    assign o_length  = length_q;
    assign o_full    = full_q;

endmodule

// File: tb/tb_aud_recorder.sv
// Bench for aud_recorder: a full-depth and a 4-word instance share one I2S
// stream; each is compared against a frame-level recording model.
module tb_aud_recorder;
    typedef struct packed {
        logic [19:0] a;
        logic [15:0] d;
    } wr_t;

    logic        i_clk = 1'b0;
    logic        i_rst_n, i_start, i_pause, i_stop, i_adclrck, i_bclk, i_adcdat;
    logic [19:0] o_address [2];
    logic [15:0] o_data [2];
    logic        o_we [2];
    logic [19:0] o_length [2];
    logic        o_full [2];

    int checks = 0;
    int errors = 0;

    wr_t got_q [2][$];
    wr_t exp_q [2][$];

    // model: 0 idle, 1 recording, 2 paused, 3 done
    int          m_mode [2];
    logic [19:0] m_addr [2], m_len [2], m_oaddr [2], m_max [2];
    logic [15:0] m_odata [2];
    logic        m_full [2];

    always #5 i_clk = ~i_clk;

    aud_recorder u_dut_big (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_pause(i_pause), .i_stop(i_stop),
        .i_adclrck(i_adclrck), .i_bclk(i_bclk), .i_adcdat(i_adcdat),
        .o_address(o_address[0]), .o_data(o_data[0]), .o_we(o_we[0]),
        .o_length(o_length[0]), .o_full(o_full[0])
    );

    aud_recorder #(.MAX_ADDR(20'h3)) u_dut_small (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_pause(i_pause), .i_stop(i_stop),
        .i_adclrck(i_adclrck), .i_bclk(i_bclk), .i_adcdat(i_adcdat),
        .o_address(o_address[1]), .o_data(o_data[1]), .o_we(o_we[1]),
        .o_length(o_length[1]), .o_full(o_full[1])
    );

    always @(negedge i_clk) begin
        if (o_we[0]) got_q[0].push_back({o_address[0], o_data[0]});
        if (o_we[1]) got_q[1].push_back({o_address[1], o_data[1]});
    end

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            m_mode[n] = 0; m_addr[n] = 20'd0; m_len[n] = 20'd0;
            m_oaddr[n] = 20'd0; m_odata[n] = 16'd0; m_full[n] = 1'b0;
        end
    endtask

    task automatic do_start();
        @(negedge i_clk) i_start = 1'b1;
        @(negedge i_clk) i_start = 1'b0;
        for (int n = 0; n < 2; n++) begin
            if (m_mode[n] == 0 || m_mode[n] == 3) begin
                m_mode[n] = 1; m_addr[n] = 20'd0; m_len[n] = 20'd0;
                m_full[n] = 1'b0; m_oaddr[n] = 20'd0;
            end else if (m_mode[n] == 2) begin
                m_mode[n] = 1;
            end
        end
    endtask

    task automatic do_stop();
        @(negedge i_clk) i_stop = 1'b1;
        @(negedge i_clk) i_stop = 1'b0;
        for (int n = 0; n < 2; n++) m_mode[n] = 0;
    endtask

    // act: 0 none, 1 pause, 2 stop, 3 reset, 4 stop+start; fired during left bit slot act_bit
    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int act_bit, input int act);
        for (int h = 0; h < 2; h++) begin
            for (int i = 0; i < 24; i++) begin
                i_bclk = 1'b0;
                if (i == 0) i_adclrck = (h == 1);
                if (h == 0 && i == 0) i_adcdat = ~l[15];
                else if (i >= 1 && i <= 16) i_adcdat = (h == 0) ? l[16-i] : r[16-i];
                else i_adcdat = 1'($urandom);
                if (h == 0 && i == act_bit && act != 0) begin
                    if (act == 1) i_pause = 1'b1;
                    if (act == 2 || act == 4) i_stop = 1'b1;
                    if (act == 4) i_start = 1'b1;
                    if (act == 3) i_rst_n = 1'b0;
                    #10;
                    i_pause = 1'b0; i_stop = 1'b0; i_start = 1'b0; i_rst_n = 1'b1;
                    #30;
                end else begin
                    #40;
                end
                i_bclk = 1'b1;
                #40;
            end
        end
        if (act == 3) begin
            model_reset();
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (act == 2 || act == 4) begin
                    m_mode[n] = 0;
                end else if (m_mode[n] == 1) begin
                    exp_q[n].push_back({m_addr[n], l});
                    m_oaddr[n] = m_addr[n];
                    m_odata[n] = l;
                    m_len[n]   = m_len[n] + 20'd1;
                    if (m_addr[n] == m_max[n]) begin
                        m_full[n] = 1'b1; m_mode[n] = 3;
                    end else begin
                        m_addr[n] = m_addr[n] + 20'd1;
                        if (act == 1) m_mode[n] = 2;
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; i_start = 1'b0; i_pause = 1'b0; i_stop = 1'b0;
        i_adclrck = 1'b1; i_bclk = 1'b0; i_adcdat = 1'b0;
        model_reset();
        repeat (3) @(negedge i_clk);
        for (int n = 0; n < 2; n++) begin
            checks++;
            if ({o_address[n], o_data[n], o_we[n], o_length[n], o_full[n]} !== 58'd0) begin
                errors++;
                $display("FAIL reset inst%0d: got addr %h data %h we %b len %h full %b, expected all zero",
                         n, o_address[n], o_data[n], o_we[n], o_length[n], o_full[n]);
            end
        end
        i_rst_n = 1'b1;
        repeat (3) @(negedge i_clk);
    endtask

    task automatic test_basic();
        do_start();
        send_frame(16'hA5C3, 16'hFFFF, 0, 0);
        send_frame(16'h1234, 16'hFFFF, 0, 0);
        send_frame(16'h8001, 16'hFFFF, 0, 0);
        checks++;
        if (o_length[0] !== 20'd3) begin
            errors++; $display("FAIL basic length: got %0d expected 3", o_length[0]);
        end
        for (int n = 0; n < 2; n++) begin
            checks++;
            if (got_q[n].size() !== exp_q[n].size()) begin
                errors++;
                $display("FAIL basic inst%0d write count: got %0d expected %0d", n, got_q[n].size(), exp_q[n].size());
            end else begin
                for (int k = 0; k < exp_q[n].size(); k++) begin
                    checks++;
                    if (got_q[n][k] !== exp_q[n][k]) begin
                        errors++;
                        $display("FAIL basic inst%0d write %0d: got %h/%h expected %h/%h", n, k,
                                 got_q[n][k].a, got_q[n][k].d, exp_q[n][k].a, exp_q[n][k].d);
                    end
                end
            end
            checks++;
            if ({o_length[n], o_full[n], o_address[n], o_data[n]} !== {m_len[n], m_full[n], m_oaddr[n], m_odata[n]}) begin
                errors++;
                $display("FAIL basic inst%0d outputs: got len %h full %b addr %h data %h expected len %h full %b addr %h data %h",
                         n, o_length[n], o_full[n], o_address[n], o_data[n], m_len[n], m_full[n], m_oaddr[n], m_odata[n]);
            end
            got_q[n].delete(); exp_q[n].delete();
        end
    endtask

    task automatic test_skip_align();
        send_frame(16'hA5C3, 16'h0000, 0, 0);
        checks++;
        if (o_data[0] !== 16'hA5C3) begin
            errors++; $display("FAIL skip_align data: got %h expected a5c3", o_data[0]);
        end
        for (int n = 0; n < 2; n++) begin
            checks++;
            if (got_q[n].size() !== exp_q[n].size()) begin
                errors++;
                $display("FAIL skip_align inst%0d write count: got %0d expected %0d", n, got_q[n].size(), exp_q[n].size());
            end else begin
                for (int k = 0; k < exp_q[n].size(); k++) begin
                    checks++;
                    if (got_q[n][k] !== exp_q[n][k]) begin
                        errors++;
                        $display("FAIL skip_align inst%0d write %0d: got %h/%h expected %h/%h", n, k,
                                 got_q[n][k].a, got_q[n][k].d, exp_q[n][k].a, exp_q[n][k].d);
                    end
                end
            end
            checks++;
            if ({o_length[n], o_full[n], o_address[n], o_data[n]} !== {m_len[n], m_full[n], m_oaddr[n], m_odata[n]}) begin
                errors++;
                $display("FAIL skip_align inst%0d outputs: got len %h full %b addr %h data %h expected len %h full %b addr %h data %h",
                         n, o_length[n], o_full[n], o_address[n], o_data[n], m_len[n], m_full[n], m_oaddr[n], m_odata[n]);
            end
            got_q[n].delete(); exp_q[n].delete();
        end
    endtask

    task automatic test_pause();
        logic [15:0] s2;
        do_stop();
        do_start();
        send_frame(16'($urandom), 16'($urandom), 0, 0);
        s2 = 16'($urandom);
        send_frame(s2, 16'($urandom), 6, 1);
        repeat (3) send_frame(16'($urandom), 16'($urandom), 0, 0);
        do_start();
        send_frame(16'($urandom), 16'($urandom), 0, 0);
        checks++;
        if (got_q[0].size() < 2 || got_q[0][1] !== {20'd1, s2}) begin
            errors++; $display("FAIL pause paused word: write count %0d, expected word %h at address 1", got_q[0].size(), s2);
        end
        for (int n = 0; n < 2; n++) begin
            checks++;
            if (got_q[n].size() !== exp_q[n].size()) begin
                errors++;
                $display("FAIL pause inst%0d write count: got %0d expected %0d", n, got_q[n].size(), exp_q[n].size());
            end else begin
                for (int k = 0; k < exp_q[n].size(); k++) begin
                    checks++;
                    if (got_q[n][k] !== exp_q[n][k]) begin
                        errors++;
                        $display("FAIL pause inst%0d write %0d: got %h/%h expected %h/%h", n, k,
                                 got_q[n][k].a, got_q[n][k].d, exp_q[n][k].a, exp_q[n][k].d);
                    end
                end
            end
            checks++;
            if ({o_length[n], o_full[n], o_address[n], o_data[n]} !== {m_len[n], m_full[n], m_oaddr[n], m_odata[n]}) begin
                errors++;
                $display("FAIL pause inst%0d outputs: got len %h full %b addr %h data %h expected len %h full %b addr %h data %h",
                         n, o_length[n], o_full[n], o_address[n], o_data[n], m_len[n], m_full[n], m_oaddr[n], m_odata[n]);
            end
            got_q[n].delete(); exp_q[n].delete();
        end
    endtask

    task automatic test_stop();
        do_stop();
        do_start();
        repeat (3) send_frame(16'($urandom), 16'($urandom), 0, 0);
        send_frame(16'($urandom), 16'($urandom), 8, 2);
        checks++;
        if (o_length[0] !== 20'd3) begin
            errors++; $display("FAIL stop length: got %0d expected 3", o_length[0]);
        end
        do_start();
        send_frame(16'($urandom), 16'($urandom), 0, 0);
        checks++;
        if (o_length[0] !== 20'd1 || o_address[0] !== 20'd0) begin
            errors++; $display("FAIL stop restart: got len %0d addr %h expected len 1 addr 0", o_length[0], o_address[0]);
        end
        for (int n = 0; n < 2; n++) begin
            checks++;
            if (got_q[n].size() !== exp_q[n].size()) begin
                errors++;
                $display("FAIL stop inst%0d write count: got %0d expected %0d", n, got_q[n].size(), exp_q[n].size());
            end else begin
                for (int k = 0; k < exp_q[n].size(); k++) begin
                    checks++;
                    if (got_q[n][k] !== exp_q[n][k]) begin
                        errors++;
                        $display("FAIL stop inst%0d write %0d: got %h/%h expected %h/%h", n, k,
                                 got_q[n][k].a, got_q[n][k].d, exp_q[n][k].a, exp_q[n][k].d);
                    end
                end
            end
            got_q[n].delete(); exp_q[n].delete();
        end
    endtask

    task automatic test_full();
        do_stop();
        do_start();
        repeat (6) send_frame(16'($urandom), 16'($urandom), 0, 0);
        checks++;
        if (o_full[1] !== 1'b1 || o_address[1] !== 20'd3 || got_q[1].size() !== 4) begin
            errors++;
            $display("FAIL full small: got full %b addr %h writes %0d expected full 1 addr 3 writes 4",
                     o_full[1], o_address[1], got_q[1].size());
        end
        for (int n = 0; n < 2; n++) begin
            checks++;
            if (got_q[n].size() !== exp_q[n].size()) begin
                errors++;
                $display("FAIL full inst%0d write count: got %0d expected %0d", n, got_q[n].size(), exp_q[n].size());
            end else begin
                for (int k = 0; k < exp_q[n].size(); k++) begin
                    checks++;
                    if (got_q[n][k] !== exp_q[n][k]) begin
                        errors++;
                        $display("FAIL full inst%0d write %0d: got %h/%h expected %h/%h", n, k,
                                 got_q[n][k].a, got_q[n][k].d, exp_q[n][k].a, exp_q[n][k].d);
                    end
                end
            end
            checks++;
            if ({o_length[n], o_full[n], o_address[n], o_data[n]} !== {m_len[n], m_full[n], m_oaddr[n], m_odata[n]}) begin
                errors++;
                $display("FAIL full inst%0d outputs: got len %h full %b addr %h data %h expected len %h full %b addr %h data %h",
                         n, o_length[n], o_full[n], o_address[n], o_data[n], m_len[n], m_full[n], m_oaddr[n], m_odata[n]);
            end
            got_q[n].delete(); exp_q[n].delete();
        end
    endtask

    task automatic test_abort();
        do_stop();
        do_start();
        send_frame(16'($urandom) | 16'h0001, 16'($urandom), 0, 0);
        send_frame(16'($urandom), 16'($urandom), 8, 3);
        for (int n = 0; n < 2; n++) begin
            checks++;
            if ({o_address[n], o_data[n], o_length[n], o_full[n]} !== 57'd0) begin
                errors++;
                $display("FAIL reset_mid inst%0d: got addr %h data %h len %h full %b expected all zero",
                         n, o_address[n], o_data[n], o_length[n], o_full[n]);
            end
        end
        do_start();
        send_frame(16'($urandom), 16'($urandom), 0, 0);
        send_frame(16'($urandom), 16'($urandom), 8, 4);
        send_frame(16'($urandom), 16'($urandom), 0, 0);
        for (int n = 0; n < 2; n++) begin
            checks++;
            if (got_q[n].size() !== exp_q[n].size()) begin
                errors++;
                $display("FAIL abort inst%0d write count: got %0d expected %0d", n, got_q[n].size(), exp_q[n].size());
            end else begin
                for (int k = 0; k < exp_q[n].size(); k++) begin
                    checks++;
                    if (got_q[n][k] !== exp_q[n][k]) begin
                        errors++;
                        $display("FAIL abort inst%0d write %0d: got %h/%h expected %h/%h", n, k,
                                 got_q[n][k].a, got_q[n][k].d, exp_q[n][k].a, exp_q[n][k].d);
                    end
                end
            end
            checks++;
            if ({o_length[n], o_full[n], o_address[n], o_data[n]} !== {m_len[n], m_full[n], m_oaddr[n], m_odata[n]}) begin
                errors++;
                $display("FAIL abort inst%0d outputs: got len %h full %b addr %h data %h expected len %h full %b addr %h data %h",
                         n, o_length[n], o_full[n], o_address[n], o_data[n], m_len[n], m_full[n], m_oaddr[n], m_odata[n]);
            end
            got_q[n].delete(); exp_q[n].delete();
        end
    endtask

    task automatic test_random();
        do_stop();
        do_start();
        for (int f = 0; f < 10; f++) begin
            send_frame(16'($urandom), 16'($urandom), $urandom_range(2, 15),
                       ($urandom_range(0, 3) == 0) ? 1 : 0);
            if ((m_mode[0] == 2 || m_mode[1] == 2) && $urandom_range(0, 1) == 1) do_start();
        end
        for (int n = 0; n < 2; n++) begin
            checks++;
            if (got_q[n].size() !== exp_q[n].size()) begin
                errors++;
                $display("FAIL random inst%0d write count: got %0d expected %0d", n, got_q[n].size(), exp_q[n].size());
            end else begin
                for (int k = 0; k < exp_q[n].size(); k++) begin
                    checks++;
                    if (got_q[n][k] !== exp_q[n][k]) begin
                        errors++;
                        $display("FAIL random inst%0d write %0d: got %h/%h expected %h/%h", n, k,
                                 got_q[n][k].a, got_q[n][k].d, exp_q[n][k].a, exp_q[n][k].d);
                    end
                end
            end
            checks++;
            if ({o_length[n], o_full[n], o_address[n], o_data[n]} !== {m_len[n], m_full[n], m_oaddr[n], m_odata[n]}) begin
                errors++;
                $display("FAIL random inst%0d outputs: got len %h full %b addr %h data %h expected len %h full %b addr %h data %h",
                         n, o_length[n], o_full[n], o_address[n], o_data[n], m_len[n], m_full[n], m_oaddr[n], m_odata[n]);
            end
            got_q[n].delete(); exp_q[n].delete();
        end
    endtask

    initial begin
        m_max[0] = 20'hFFFFF;
        m_max[1] = 20'h3;
        test_reset();
        test_basic();
        test_skip_align();
        test_pause();
        test_stop();
        test_full();
        test_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/aud_recorder.md
Name: aud_recorder

Overview:
Capture side of the audio path. Receives serial I2S samples from the codec ADC and writes one 16-bit left-channel sample per frame into SRAM at consecutive addresses. The playback DSP later reads the same SRAM region. Sits between the codec's ADC pins and the SRAM arbiter, under the top-level record/play controller.

Parameters:
MAX_ADDR, 20'hFFFFF, last SRAM word address that may be written; recording stops after writing it.
WORD_BITS, 16, sample width in bits (MSB first).

Ports:
i_clk  in  1  system clock; all logic in this domain
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  one-cycle pulse: begin new recording (from IDLE/DONE) or resume (from PAUSED)
i_pause  in  1  one-cycle pulse: pause at next word boundary
i_stop  in  1  one-cycle pulse: abort recording
i_adclrck  in  1  codec ADC LR clock, asynchronous to i_clk
i_bclk  in  1  codec bit clock, asynchronous to i_clk
i_adcdat  in  1  codec ADC serial data
o_address  out  20  SRAM write address
o_data  out  16  SRAM write data
o_we  out  1  one-cycle SRAM write strobe
o_length  out  20  count of samples written in current/last recording
o_full  out  1  high when MAX_ADDR has been written

Behaviour:
- Reset (async, i_rst_n=0): state IDLE, o_address=0, o_data=0, o_we=0, o_length=0, o_full=0, shift reg=0, bit count=0, pause_pend=0.
- i_adclrck, i_bclk and i_adcdat each pass through a 2-flop synchronizer. A third flop on bclk/lrck gives edge detection. Data is sampled from the same synchronizer stage as the detected bclk edge, so bit alignment is preserved.
- i_clk must be ≥4× bclk frequency.
- Frame format (I2S):
  - Left channel while lrck=0.
  - MSB is on the 2nd bclk rising edge after the lrck falling edge; the first rising edge is skipped.
  - 16 bits captured on 16 consecutive rising edges. The right channel is ignored.
- States:
  - IDLE: outputs hold. i_start → WAIT_LR; o_address=0, o_length=0, o_full=0.
  - WAIT_LR: wait for synced lrck falling edge → SKIP.
  - SKIP: wait one synced bclk rising edge → SHIFT; bit count=0.
  - SHIFT: on each synced bclk rising edge, shift reg = {shift[14:0], adcdat}, bit count+1. After the 16th bit → WRITE on the next i_clk cycle.
  - WRITE (1 cycle):
    - o_we=1, o_data=shift reg, o_address = current address.
    - Next cycle: o_we=0, o_length+1.
    - If address==MAX_ADDR → DONE, o_full=1, address held.
    - Else address+1, then → PAUSED if pause_pend (clear it), otherwise → WAIT_LR.
  - PAUSED: no capture. i_start → WAIT_LR with address and length kept. i_stop → IDLE.
  - DONE: holds o_full=1. i_start acts as in IDLE (new recording from address 0).
- o_data and o_address hold their last written values until the next WRITE.
- Pause:
  - i_pause in WAIT_LR → PAUSED immediately.
  - In SKIP/SHIFT → sets pause_pend; the current word completes and is written first.
  - Ignored in IDLE/DONE.
- Stop: i_stop in any state except IDLE → IDLE next cycle.
  - A partial word is discarded; no o_we is issued.
  - o_length keeps the number of completed words; pause_pend cleared.
- Simultaneous pulses: stop > pause > start.
- i_start while in WAIT_LR/SKIP/SHIFT/WRITE: ignored.
- lrck rises (right channel) before 16 bits are captured: word discarded, → WAIT_LR, no write.
- Reset mid-word: everything returns to reset values immediately; no write.
- o_length saturates at MAX_ADDR+1 (full-depth recording = 2^20 with default, fits 20 bits as 0 after wrap; o_full disambiguates).

Test Plan:
- Reset, then i_start. Stream left samples 16'hA5C3, 16'h1234, 16'h8001 (bclk = i_clk/8) → three o_we pulses at addresses 0,1,2 with those data; o_length=3; right-channel data 16'hFFFF never written.
- Skip-bit alignment: drive the bit on the 1st bclk rise after the lrck fall opposite to the MSB → o_data shows the intended 16'hA5C3, unaffected.
- Pause mid-word on sample 2, then i_start after 3 frames → sample 2 is written at address 1. Frames received while paused are not written. The next frame after resume is written at address 2.
- i_stop at bit 8 of the 4th word → no write for it, o_length=3, state IDLE. A new i_start then writes its first sample at address 0, with o_length=1 after it.
- MAX_ADDR=20'h3 instance, record 6 frames → writes at addresses 0..3 only; o_full=1 after the 4th write; o_address stays 3.
- i_rst_n pulsed low during SHIFT, and separately i_stop+i_start in the same cycle → all outputs return to 0 with no o_we; stop wins, state IDLE.
